// File: rtl/simple_processor_pkg.sv
// Shared processor bus widths.
// Elaboration-time constants only; no timing or flow control here.
// Consumers size their address and data ports from these values.
package simple_processor_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
endpackage

// File: rtl/simple_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, data side first.
// Latency: mem_req_o one cycle after a request is sampled; ack forwarded in the mem_ack_i cycle.
// Backpressure: requests hold until ack; memory wait is unbounded; one idle bubble between grants.
module simple_mem_arbiter #(
    parameter int ADDR_WIDTH      = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = simple_processor_pkg::DATA_WIDTH,
    parameter int MAX_DMEM_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  busy_o,
    output logic                  spurious_ack_o
);

    localparam int SW = $clog2(MAX_DMEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DMEM_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          imem_starved;

    // Fetch has waited through a full streak of data grants: it wins this round.
    assign imem_starved = imem_req_i && (streak == STREAK_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            streak         <= '0;
            busy_o         <= 1'b0;
            spurious_ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_ack_i) begin
                        spurious_ack_o <= 1'b1;
                    end
                    if (dmem_req_i && !imem_starved) begin
                        state       <= GRANT_D;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dmem_we_i;
                        mem_addr_o  <= dmem_addr_i;
                        mem_wdata_o <= dmem_wdata_i;
                        busy_o      <= 1'b1;
                        if (imem_req_i && (streak != STREAK_MAX)) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (imem_req_i) begin
                        state       <= GRANT_I;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= imem_addr_i;
                        mem_wdata_o <= '0;
                        busy_o      <= 1'b1;
                        streak      <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Returning to IDLE on ack creates the bubble that prevents double service.
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_ack_o   = (state == GRANT_I) && mem_ack_i;
    assign dmem_ack_o   = (state == GRANT_D) && mem_ack_i;
    assign imem_rdata_o = imem_ack_o ? mem_rdata_i : '0;
    assign dmem_rdata_o = dmem_ack_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Directed self-checking bench for simple_mem_arbiter.
module tb_simple_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk_i;
    logic          rst_i;
    logic          imem_req_i;
    logic [AW-1:0] imem_addr_i;
    logic [DW-1:0] imem_rdata_o;
    logic          imem_ack_o;
    logic          dmem_req_i;
    logic          dmem_we_i;
    logic [AW-1:0] dmem_addr_i;
    logic [DW-1:0] dmem_wdata_i;
    logic [DW-1:0] dmem_rdata_o;
    logic          dmem_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;
    logic          busy_o;
    logic          spurious_ack_o;

    int checks = 0;
    int errors = 0;

    simple_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DMEM_STREAK(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .imem_req_i(imem_req_i),
        .imem_addr_i(imem_addr_i),
        .imem_rdata_o(imem_rdata_o),
        .imem_ack_o(imem_ack_o),
        .dmem_req_i(dmem_req_i),
        .dmem_we_i(dmem_we_i),
        .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i),
        .dmem_rdata_o(dmem_rdata_o),
        .dmem_ack_o(dmem_ack_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i),
        .busy_o(busy_o),
        .spurious_ack_o(spurious_ack_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after the rising edge; outputs are sampled 8ns after it.
    task automatic cycle_begin();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #7;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        imem_req_i = 1'b0; imem_addr_i = '0;
        dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        repeat (2) begin
            cycle_begin();
            settle();
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req_o); end
            checks++; if (mem_addr_o !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got %h exp 0000", mem_addr_o); end
            checks++; if (spurious_ack_o !== 1'b0) begin errors++; $display("FAIL rst_spurious got %b exp 0", spurious_ack_o); end
        end
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle_begin();
            settle();
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_mem_req cyc %0d got %b exp 0", c, mem_req_o); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy cyc %0d got %b exp 0", c, busy_o); end
            checks++; if ({imem_ack_o, dmem_ack_o} !== 2'b00) begin errors++; $display("FAIL idle_acks cyc %0d got %b exp 00", c, {imem_ack_o, dmem_ack_o}); end
        end
    endtask

    task automatic test_single_fetch();
        cycle_begin();
        imem_req_i = 1'b1; imem_addr_i = 16'h0010;
        settle();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c0_req got %b exp 0", mem_req_o); end
        for (int c = 1; c <= 3; c++) begin
            cycle_begin();
            mem_ack_i   = (c == 3);
            mem_rdata_i = (c == 3) ? 16'hA5A5 : 16'h0000;
            settle();
            checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL fetch_req c%0d got %b exp 1", c, mem_req_o); end
            checks++; if (mem_addr_o !== 16'h0010) begin errors++; $display("FAIL fetch_addr c%0d got %h exp 0010", c, mem_addr_o); end
            checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL fetch_we c%0d got %b exp 0", c, mem_we_o); end
            checks++; if (imem_ack_o !== (c == 3)) begin errors++; $display("FAIL fetch_ack c%0d got %b exp %b", c, imem_ack_o, (c == 3)); end
            checks++; if (imem_rdata_o !== ((c == 3) ? 16'hA5A5 : 16'h0000)) begin errors++; $display("FAIL fetch_rdata c%0d got %h", c, imem_rdata_o); end
            checks++; if ({dmem_ack_o, dmem_rdata_o} !== 17'h0) begin errors++; $display("FAIL fetch_dside c%0d got %b/%h exp 0/0000", c, dmem_ack_o, dmem_rdata_o); end
        end
        cycle_begin();
        imem_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fetch_c4_req got %b exp 0", mem_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fetch_c4_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_contention();
        cycle_begin();
        imem_req_i = 1'b1; imem_addr_i = 16'h0020;
        dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 16'h0040; dmem_wdata_i = 16'h1234;
        settle();
        cycle_begin();
        settle();
        checks++; if ({mem_req_o, mem_we_o} !== 2'b11) begin errors++; $display("FAIL cont_d_req_we got %b exp 11", {mem_req_o, mem_we_o}); end
        checks++; if (mem_addr_o !== 16'h0040) begin errors++; $display("FAIL cont_d_addr got %h exp 0040", mem_addr_o); end
        checks++; if (mem_wdata_o !== 16'h1234) begin errors++; $display("FAIL cont_d_wdata got %h exp 1234", mem_wdata_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cont_d_busy got %b exp 1", busy_o); end
        cycle_begin();
        mem_ack_i = 1'b1; mem_rdata_i = 16'h5555;
        settle();
        checks++; if ({dmem_ack_o, imem_ack_o} !== 2'b10) begin errors++; $display("FAIL cont_d_ack got %b exp 10", {dmem_ack_o, imem_ack_o}); end
        checks++; if (dmem_rdata_o !== 16'h5555) begin errors++; $display("FAIL cont_d_rdata got %h exp 5555", dmem_rdata_o); end
        checks++; if (imem_rdata_o !== 16'h0000) begin errors++; $display("FAIL cont_i_rdata_quiet got %h exp 0000", imem_rdata_o); end
        cycle_begin();
        dmem_req_i = 1'b0; dmem_we_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL cont_bubble got %b exp 0", mem_req_o); end
        cycle_begin();
        mem_ack_i = 1'b1; mem_rdata_i = 16'h7777;
        settle();
        checks++; if ({mem_req_o, mem_we_o} !== 2'b10) begin errors++; $display("FAIL cont_i_req_we got %b exp 10", {mem_req_o, mem_we_o}); end
        checks++; if ({mem_addr_o, mem_wdata_o} !== {16'h0020, 16'h0000}) begin errors++; $display("FAIL cont_i_addr_wdata got %h/%h exp 0020/0000", mem_addr_o, mem_wdata_o); end
        checks++; if ({imem_ack_o, dmem_ack_o} !== 2'b10) begin errors++; $display("FAIL cont_i_ack got %b exp 10", {imem_ack_o, dmem_ack_o}); end
        cycle_begin();
        imem_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
    endtask

    task automatic test_starvation_guard();
        int   n;
        logic exp_i;
        n = 0;
        imem_req_i = 1'b1; imem_addr_i = 16'h0100;
        dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 16'h0080;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            cycle_begin();
            mem_ack_i = mem_req_o;
            mem_rdata_i = 16'h0F0F;
            settle();
            if (imem_ack_o || dmem_ack_o) begin
                exp_i = ((n % 5) == 4);
                checks++; if ({imem_ack_o, dmem_ack_o} !== {exp_i, ~exp_i}) begin errors++; $display("FAIL starve_grant %0d got i/d %b%b exp %b%b", n, imem_ack_o, dmem_ack_o, exp_i, ~exp_i); end
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL starve_count got %0d exp 10", n); end
        cycle_begin();
        imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
    endtask

    task automatic test_reset_mid_txn();
        cycle_begin();
        dmem_req_i = 1'b1; dmem_we_i = 1'b1; dmem_addr_i = 16'h0030; dmem_wdata_i = 16'hBEEF;
        settle();
        cycle_begin();
        settle();
        checks++; if ({mem_req_o, busy_o, mem_we_o} !== 3'b111) begin errors++; $display("FAIL rmid_grant got %b exp 111", {mem_req_o, busy_o, mem_we_o}); end
        cycle_begin();
        rst_i = 1'b1;
        settle();
        checks++; if (dmem_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_rst_ack got %b exp 0", dmem_ack_o); end
        cycle_begin();
        rst_i = 1'b0; dmem_req_i = 1'b0; dmem_we_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 16'h9999;
        settle();
        checks++; if ({mem_req_o, busy_o, mem_we_o} !== 3'b000) begin errors++; $display("FAIL rmid_after got %b exp 000", {mem_req_o, busy_o, mem_we_o}); end
        checks++; if (mem_addr_o !== 16'h0000) begin errors++; $display("FAIL rmid_addr got %h exp 0000", mem_addr_o); end
        checks++; if ({imem_ack_o, dmem_ack_o} !== 2'b00) begin errors++; $display("FAIL rmid_late_ack got %b exp 00", {imem_ack_o, dmem_ack_o}); end
        checks++; if (dmem_rdata_o !== 16'h0000) begin errors++; $display("FAIL rmid_rdata got %h exp 0000", dmem_rdata_o); end
        checks++; if (spurious_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_spur_pre got %b exp 0", spurious_ack_o); end
        cycle_begin();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
        checks++; if (spurious_ack_o !== 1'b1) begin errors++; $display("FAIL rmid_spur_set got %b exp 1", spurious_ack_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_spur_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_zero_wait();
        logic exp_i;
        for (int k = 0; k < 12; k++) begin
            cycle_begin();
            if (k == 0) begin
                imem_req_i = 1'b1; imem_addr_i = 16'h0200;
                dmem_req_i = 1'b1; dmem_we_i = 1'b0; dmem_addr_i = 16'h0300;
                mem_ack_i = 1'b1; mem_rdata_i = 16'h3C3C;
            end
            settle();
            checks++; if (mem_req_o !== ((k % 2) == 1)) begin errors++; $display("FAIL zw_req k%0d got %b exp %b", k, mem_req_o, ((k % 2) == 1)); end
            if ((k % 2) == 1) begin
                exp_i = ((((k - 1) / 2) % 5) == 4);
                checks++; if ({imem_ack_o, dmem_ack_o} !== {exp_i, ~exp_i}) begin errors++; $display("FAIL zw_ack k%0d got %b%b exp %b%b", k, imem_ack_o, dmem_ack_o, exp_i, ~exp_i); end
                checks++; if ((imem_rdata_o | dmem_rdata_o) !== 16'h3C3C) begin errors++; $display("FAIL zw_rdata k%0d got %h/%h exp 3c3c", k, imem_rdata_o, dmem_rdata_o); end
            end else begin
                checks++; if ({imem_ack_o, dmem_ack_o} !== 2'b00) begin errors++; $display("FAIL zw_bubble_ack k%0d got %b exp 00", k, {imem_ack_o, dmem_ack_o}); end
            end
        end
        cycle_begin();
        imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        settle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation_guard();
        test_reset_mid_txn();
        test_zero_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
